// File: rtl/adder_cell_pair.sv
// Per-lane half adder (a+b) and full adder (a+b+c) evaluated in parallel, no carry between lanes.
// Latency: 1 cycle with OUT_REG=1 (valid-tagged), 0 cycles with OUT_REG=0 (pure combinational).
// Backpressure: none; accepts one operand set per cycle whenever in_valid is high, never stalls.
module adder_cell_pair #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum1,
  output logic [WIDTH-1:0] carry1,
  output logic             out_valid
);

  // Lane results before the optional output register.
  logic [WIDTH-1:0] ha_sum;
  logic [WIDTH-1:0] ha_carry;
  logic [WIDTH-1:0] fa_sum;
  logic [WIDTH-1:0] fa_carry;

  // Each lane is built from its own bits only, so an X on one lane cannot
  // leak into a neighbour through a shared vector expression.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign ha_sum[i]   = a[i] ^ b[i];
    assign ha_carry[i] = a[i] & b[i];
    assign fa_sum[i]   = a[i] ^ b[i] ^ c[i];
    assign fa_carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  if (OUT_REG) begin : g_reg
    // Result registers load only on accepted operands; out_valid pulses one cycle per accept.
    // Reset wins over in_valid so an operand presented on the reset edge is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum       <= '0;
        carry     <= '0;
        sum1      <= '0;
        carry1    <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          sum    <= ha_sum;
          carry  <= ha_carry;
          sum1   <= fa_sum;
          carry1 <= fa_carry;
        end
      end
    end
  end else begin : g_comb
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sum       = ha_sum;
    assign carry     = ha_carry;
    assign sum1      = fa_sum;
    assign carry1    = fa_carry;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_adder_cell_pair.sv
module tb_adder_cell_pair;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 4-lane instance
  logic       rst = 1'b0;
  logic       iv  = 1'b0;
  logic [3:0] a = '0, b = '0, c = '0;
  logic [3:0] sum, carry, sum1, carry1;
  logic       ov;

  // Combinational 1-lane instance
  logic       civ = 1'b0;
  logic [0:0] ca = '0, cb = '0, cc = '0;
  logic [0:0] csum, ccarry, csum1, ccarry1;
  logic       cov;

  // Bench-side expected values for the registered instance
  logic [3:0] e_sum, e_carry, e_sum1, e_carry1;

  // Hand-written truth tables: ha_tab[{a,b}] = {carry,sum}, fa_tab[{a,b,c}] = {carry1,sum1}
  logic [1:0] ha_tab [4];
  logic [1:0] fa_tab [8];

  adder_cell_pair #(.WIDTH(4), .OUT_REG(1'b1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a), .b(b), .c(c),
    .sum(sum), .carry(carry), .sum1(sum1), .carry1(carry1), .out_valid(ov)
  );

  adder_cell_pair #(.WIDTH(1), .OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(civ), .a(ca), .b(cb), .c(cc),
    .sum(csum), .carry(ccarry), .sum1(csum1), .carry1(ccarry1), .out_valid(cov)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; a = 4'hF; b = 4'hF; c = 4'hF;
    @(posedge clk); #1;
    total++;
    if ({sum, carry, sum1, carry1} !== 16'h0000) begin
      bad++; $display("FAIL reset_results got=%h want=0000", {sum, carry, sum1, carry1});
    end
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ov); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      ca = v[2]; cb = v[1]; cc = v[0]; civ = v[0] ^ v[1];
      #2;
      total++;
      if ({ccarry, csum} !== ha_tab[v[2:1]]) begin
        bad++; $display("FAIL comb_ha abc=%b got=%b want=%b", v, {ccarry, csum}, ha_tab[v[2:1]]);
      end
      total++;
      if ({ccarry1, csum1} !== fa_tab[v]) begin
        bad++; $display("FAIL comb_fa abc=%b got=%b want=%b", v, {ccarry1, csum1}, fa_tab[v]);
      end
      total++;
      if (cov !== (v[0] ^ v[1])) begin
        bad++; $display("FAIL comb_valid abc=%b got=%b want=%b", v, cov, v[0] ^ v[1]);
      end
    end
    // Explicit spot values
    ca = 1'b1; cb = 1'b1; cc = 1'b0; #2;
    total++;
    if ({csum, ccarry, csum1, ccarry1} !== 4'b0101) begin
      bad++; $display("FAIL comb_110 got=%b want=0101", {csum, ccarry, csum1, ccarry1});
    end
    cc = 1'b1; #2;
    total++;
    if ({csum1, ccarry1} !== 2'b11) begin
      bad++; $display("FAIL comb_111 got=%b want=11", {csum1, ccarry1});
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    iv = 1'b1; a = 4'b0001; b = 4'b0000; c = 4'b0001;
    @(posedge clk); #1;
    iv = 1'b0; a = 4'b1111; b = 4'b1111; c = 4'b1111;
    total++;
    if ({sum, carry, sum1, carry1} !== {4'b0001, 4'b0000, 4'b0000, 4'b0001}) begin
      bad++; $display("FAIL lat_results got=%b want=0001000000000001", {sum, carry, sum1, carry1});
    end
    total++;
    if (ov !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", ov); end
    @(posedge clk); #1;
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL lat_valid_drop got=%b want=0", ov); end
    total++;
    if ({sum, carry, sum1, carry1} !== {4'b0001, 4'b0000, 4'b0000, 4'b0001}) begin
      bad++; $display("FAIL lat_hold got=%b want=0001000000000001", {sum, carry, sum1, carry1});
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; iv = 1'b1; a = 4'hF; b = 4'hF; c = 4'hF;
    @(posedge clk); #1;
    total++;
    if ({sum, carry, sum1, carry1} !== 16'h0000) begin
      bad++; $display("FAIL rstpri_results got=%h want=0000", {sum, carry, sum1, carry1});
    end
    total++;
    if (ov !== 1'b0) begin bad++; $display("FAIL rstpri_valid got=%b want=0", ov); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0;
    total++;
    if ({sum, carry, sum1, carry1} !== 16'h0FFF) begin
      bad++; $display("FAIL rstpri_load got=%h want=0fff", {sum, carry, sum1, carry1});
    end
    total++;
    if (ov !== 1'b1) begin bad++; $display("FAIL rstpri_load_valid got=%b want=1", ov); end
  endtask

  task automatic test_lanes();
    @(negedge clk);
    iv = 1'b1; a = 4'b1100; b = 4'b1010; c = 4'b0110;
    @(posedge clk); #1;
    iv = 1'b0;
    total++;
    if (sum !== 4'b0110) begin bad++; $display("FAIL lanes_sum got=%b want=0110", sum); end
    total++;
    if (carry !== 4'b1000) begin bad++; $display("FAIL lanes_carry got=%b want=1000", carry); end
    total++;
    if (sum1 !== 4'b0000) begin bad++; $display("FAIL lanes_sum1 got=%b want=0000", sum1); end
    total++;
    if (carry1 !== 4'b1110) begin bad++; $display("FAIL lanes_carry1 got=%b want=1110", carry1); end
  endtask

  task automatic test_back_to_back();
    // Lane i carries operand pattern (k+i) mod 8 as {a,b,c}
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      iv = 1'b1;
      for (int i = 0; i < 4; i++) begin
        logic [2:0] v;
        v = 3'(k + i);
        a[i] = v[2]; b[i] = v[1]; c[i] = v[0];
        {e_carry[i], e_sum[i]}   = ha_tab[v[2:1]];
        {e_carry1[i], e_sum1[i]} = fa_tab[v];
      end
      @(posedge clk); #1;
      total++;
      if (ov !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b want=1", k, ov); end
      total++;
      if ({sum, carry} !== {e_sum, e_carry}) begin
        bad++; $display("FAIL stream_ha k=%0d got=%b want=%b", k, {sum, carry}, {e_sum, e_carry});
      end
      total++;
      if ({sum1, carry1} !== {e_sum1, e_carry1}) begin
        bad++; $display("FAIL stream_fa k=%0d got=%b want=%b", k, {sum1, carry1}, {e_sum1, e_carry1});
      end
    end
    @(negedge clk);
    iv = 1'b0;
  endtask

  task automatic test_hold();
    for (int k = 0; k < 3; k++) begin
      a = 4'(k * 5 + 3); b = 4'(k * 7 + 9); c = 4'(k * 3 + 6);
      @(posedge clk); #1;
      total++;
      if (ov !== 1'b0) begin bad++; $display("FAIL hold_valid k=%0d got=%b want=0", k, ov); end
      total++;
      if ({sum, carry, sum1, carry1} !== {e_sum, e_carry, e_sum1, e_carry1}) begin
        bad++; $display("FAIL hold_results k=%0d got=%b want=%b", k,
                        {sum, carry, sum1, carry1}, {e_sum, e_carry, e_sum1, e_carry1});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    ha_tab[0] = 2'b00; ha_tab[1] = 2'b01; ha_tab[2] = 2'b01; ha_tab[3] = 2'b10;
    fa_tab[0] = 2'b00; fa_tab[1] = 2'b01; fa_tab[2] = 2'b01; fa_tab[3] = 2'b10;
    fa_tab[4] = 2'b01; fa_tab[5] = 2'b10; fa_tab[6] = 2'b10; fa_tab[7] = 2'b11;
    e_sum = '0; e_carry = '0; e_sum1 = '0; e_carry1 = '0;

    test_reset();
    test_comb_sweep();
    test_latency();
    test_reset_priority();
    test_lanes();
    test_back_to_back();
    test_hold();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_cell_pair.md
Name: adder_cell_pair

Overview:
- Bit-sliced arithmetic primitive: each bit lane contains one half adder (a+b) and one full adder (a+b+c), evaluated in parallel on the same operands.
- Used as the leaf cell under wider ripple/carry-save adders and as a standalone teaching/verification primitive.
- Results are either registered (one-cycle latency, valid-tagged) or purely combinational, selected by parameter.

Parameters:
- WIDTH, 1, number of independent bit lanes; each lane is its own half adder + full adder, with no carry between lanes.
- OUT_REG, 1, 1 = all outputs registered on clk; 0 = outputs combinational from inputs, and clk/rst affect nothing.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on a/b/c are valid this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- c  input  WIDTH  carry-in per lane (full adder only).
- sum  output  WIDTH  half-adder sum per lane = a XOR b.
- carry  output  WIDTH  half-adder carry per lane = a AND b.
- sum1  output  WIDTH  full-adder sum per lane = a XOR b XOR c.
- carry1  output  WIDTH  full-adder carry per lane = (a&b)|(a&c)|(b&c).
- out_valid  output  1  sum/carry/sum1/carry1 hold a valid result.

Behaviour:
- Lane i depends only on a[i], b[i] and c[i]. There is no inter-lane carry; chaining lanes is the parent's job.
- Half adder truth table (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
- Full adder truth table (a,b,c -> sum1,carry1): 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
- Invariants per lane: {carry,sum} = a+b, and {carry1,sum1} = a+b+c, as 2-bit unsigned values.
- c has no effect on sum or carry.

OUT_REG=1:
- Latency is exactly 1 cycle. Operands sampled at rising edge N appear on the outputs after edge N and hold until the next accepted operand set.
- Result registers load only when in_valid=1. When in_valid=0 the registers hold their last value.
- out_valid is registered: out_valid <= in_valid each edge, so it is high for exactly one cycle per accepted operand set.
- Back-to-back in_valid gives one result per cycle; throughput is 1/cycle and there are no stalls.
- rst=1 at a rising edge takes priority over in_valid. It clears sum, carry, sum1, carry1 and out_valid to 0.
- Reset mid-stream drops any operand sampled on the reset edge; the first result after reset comes from the first in_valid edge with rst=0.
- Before the first reset, register contents are unspecified; the verifier checks outputs only after reset.

OUT_REG=0:
- All four result outputs are continuous functions of a/b/c, with zero latency.
- out_valid = in_valid, combinationally.
- rst and clk are ignored, and no state exists.

General:
- X/Z on any input of a lane may propagate to that lane's outputs only. Other lanes must be unaffected.
- No internal state other than the output registers.

Test Plan:
- Combinational sweep (OUT_REG=0, WIDTH=1): step a,b,c through all 8 combinations -> outputs match both truth tables each step, e.g. a=1,b=1,c=0 -> sum=0, carry=1, sum1=0, carry1=1; a=1,b=1,c=1 -> sum1=1, carry1=1.
- Registered latency (OUT_REG=1): reset, then drive a=1,b=0,c=1,in_valid=1 for one edge -> next cycle sum=1, carry=0, sum1=0, carry1=1, out_valid=1; following cycle out_valid=0 with results held.
- Reset priority: rst=1 and in_valid=1 with a=b=c=1 at the same edge -> all outputs 0 and out_valid=0 after that edge. The next edge with rst=0 and in_valid=1 loads the operands.
- Multi-lane independence (WIDTH=4): a=4'b1100, b=4'b1010, c=4'b0110 -> sum=0110, carry=1000, sum1=0000, carry1=1110.
- Streaming: in_valid held high for 8 cycles while a,b,c count 000..111 -> out_valid high for 8 consecutive cycles. Each result matches its operands from the previous cycle, and {carry1,sum1} equals the popcount of that cycle's a,b,c.
- Hold behaviour: after a valid result, drive new a/b/c with in_valid=0 for 3 cycles -> outputs unchanged and out_valid=0.
